intadd3_acc_pipe: RTL and testbench

// Parametrised successor of the SMC 3-input lane adder. Splits DATA_W buses into LANE_W lanes and sign/zero-extends each operand.

---
 rtl/intadd3_acc_pipe.sv | 166 ++++++++++++++++
 tb/tb_intadd3_acc_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intadd3_acc_pipe.sv
// intadd3_acc_pipe: per-lane three-operand adder with optional accumulation,
// saturate/wrap to SAT_W and a two-stage valid/ready pipeline.
module intadd3_acc_pipe #(
    parameter int DATA_W = 128,
    parameter int LANE_W = 4,
    parameter int SAT_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] src0,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              sign_s0,
    input  logic              sign_s1,
    input  logic              sign_s2,
    input  logic [1:0]        op,
    input  logic              sat_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dst0,
    output logic [DATA_W-1:0] dst1,
    output logic              sat_o,
    output logic [CNT_W-1:0]  sat_cnt
);

    localparam int NLANE = DATA_W / LANE_W;
    // three unsigned lanes need two growth bits plus a sign bit
    localparam int SW    = LANE_W + 3;
    localparam int RW    = SAT_W + 2;
    localparam int DW    = 2 * LANE_W;

    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;

    localparam logic signed [RW-1:0] MAXV = RW'((1 << (SAT_W - 1)) - 1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    logic                         r_s1_valid;
    logic [NLANE-1:0][SW-1:0]     r_s1_sum;
    logic [1:0]                   r_s1_op;
    logic                         r_s1_sat;

    logic                         r_out_valid;
    logic [DATA_W-1:0]            r_dst0;
    logic [DATA_W-1:0]            r_dst1;
    logic                         r_sat_o;
    logic [CNT_W-1:0]             r_sat_cnt;
    logic [NLANE-1:0][SAT_W-1:0]  r_acc;

    logic                         w_s2_adv;
    logic                         w_s1_adv;
    logic                         w_accept;
    logic                         w_acc_wr;
    logic [NLANE-1:0][SW-1:0]     w_sum;
    logic [NLANE-1:0][SAT_W-1:0]  w_res;
    logic [NLANE-1:0]             w_lsat;
    logic [DATA_W-1:0]            w_dst0;
    logic [DATA_W-1:0]            w_dst1;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign w_acc_wr = (r_s1_op == OP_ACC) || (r_s1_op == OP_LOAD);

    assign in_ready  = w_s1_adv;
    assign out_valid = r_out_valid;
    assign dst0      = r_dst0;
    assign dst1      = r_dst1;
    assign sat_o     = r_sat_o;
    assign sat_cnt   = r_sat_cnt;

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        logic [LANE_W-1:0]       w_a;
        logic [LANE_W-1:0]       w_b;
        logic [LANE_W-1:0]       w_c;
        logic [SW-1:0]           w_ea;
        logic [SW-1:0]           w_eb;
        logic [SW-1:0]           w_ec;
        logic signed [SW-1:0]    w_s;
        logic signed [SAT_W-1:0] w_acc_s;
        logic signed [RW-1:0]    w_r;
        logic                    w_hi;
        logic                    w_lo;
        logic [DW-1:0]           w_ext;

        assign w_a  = src0[i*LANE_W +: LANE_W];
        assign w_b  = src1[i*LANE_W +: LANE_W];
        assign w_c  = src2[i*LANE_W +: LANE_W];
        assign w_ea = sign_s0 ? SW'($signed(w_a)) : SW'(w_a);
        assign w_eb = sign_s1 ? SW'($signed(w_b)) : SW'(w_b);
        assign w_ec = sign_s2 ? SW'($signed(w_c)) : SW'(w_c);
        assign w_sum[i] = w_ea + w_eb + w_ec;

        assign w_s     = r_s1_sum[i];
        assign w_acc_s = r_acc[i];
        assign w_r = (r_s1_op == OP_ACC)
                   ? RW'(w_acc_s) + RW'(w_s)
                   : RW'(w_s);

        assign w_hi = w_r > MAXV;
        assign w_lo = w_r < MINV;
        assign w_lsat[i] = r_s1_sat && (w_hi || w_lo);

        assign w_res[i] = !r_s1_sat ? w_r[SAT_W-1:0]
                        : w_hi      ? MAXV[SAT_W-1:0]
                        : w_lo      ? MINV[SAT_W-1:0]
                        :             w_r[SAT_W-1:0];

        // result is signed SAT_W, widened to two lanes before splitting
        assign w_ext = DW'($signed(w_res[i]));
        assign w_dst0[i*LANE_W +: LANE_W] = w_ext[LANE_W-1:0];
        assign w_dst1[i*LANE_W +: LANE_W] = w_ext[DW-1:LANE_W];
    end

    // stage 1: capture per-lane three-operand sums on accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_op    <= 2'b00;
            r_s1_sat   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_sum <= w_sum;
                r_s1_op  <= op;
                r_s1_sat <= sat_en;
            end
        end
    end

    // stage 2: register lane results and update accumulators on entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_dst0      <= '0;
            r_dst1      <= '0;
            r_sat_o     <= 1'b0;
            r_acc       <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dst0  <= w_dst0;
                r_dst1  <= w_dst1;
                r_sat_o <= |w_lsat;
                if (w_acc_wr) begin
                    r_acc <= w_res;
                end
            end
        end
    end

    // count consumed saturating beats, sticking at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (r_out_valid && out_ready && r_sat_o
                     && (r_sat_cnt != {CNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_intadd3_acc_pipe.sv
// tb_intadd3_acc_pipe: directed vectors with a queued scoreboard; a
// second instance with SAT_W=6 covers the narrow-result clamp.
module tb_intadd3_acc_pipe;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] ACC  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] src0, src1, src2;
    logic         sign_s0, sign_s1, sign_s2;
    logic [1:0]   op;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dst0, dst1;
    logic         sat_o;
    logic [15:0]  sat_cnt;

    logic         o6_in_ready;
    logic         o6_valid;
    logic [127:0] o6_dst0, o6_dst1;
    logic         o6_sat;
    logic [15:0]  o6_cnt;

    typedef struct {
        logic [127:0] d0;
        logic [127:0] d1;
        logic         s;
    } exp_t;

    typedef struct {
        logic         care;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         s;
    } exp6_t;

    exp_t  q[$];
    exp6_t q6[$];
    exp_t  m_e;
    exp6_t m_e6;

    logic         c6 = 1'b0;
    logic [127:0] c6_d0 = '0;
    logic [127:0] c6_d1 = '0;
    logic         c6_s = 1'b0;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int base;

    always #5 clk = ~clk;

    intadd3_acc_pipe #(
        .DATA_W(128), .LANE_W(4), .SAT_W(8), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .src0(src0), .src1(src1), .src2(src2),
        .sign_s0(sign_s0), .sign_s1(sign_s1), .sign_s2(sign_s2),
        .op(op), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .dst0(dst0), .dst1(dst1),
        .sat_o(sat_o), .sat_cnt(sat_cnt)
    );

    intadd3_acc_pipe #(
        .DATA_W(128), .LANE_W(4), .SAT_W(6), .CNT_W(16)
    ) u_dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(o6_in_ready),
        .src0(src0), .src1(src1), .src2(src2),
        .sign_s0(sign_s0), .sign_s1(sign_s1), .sign_s2(sign_s2),
        .op(op), .sat_en(sat_en),
        .out_valid(o6_valid), .out_ready(out_ready),
        .dst0(o6_dst0), .dst1(o6_dst1),
        .sat_o(o6_sat), .sat_cnt(o6_cnt)
    );

    function automatic logic [127:0] rep(input logic [3:0] n);
        return {32{n}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pop and compare whenever a beat is consumed
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) n_acc++;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got beat expected none");
            end else begin
                m_e = q.pop_front();
                chk("dst0", dst0, m_e.d0);
                chk("dst1", dst1, m_e.d1);
                chk("sat_o", {127'b0, sat_o}, {127'b0, m_e.s});
            end
        end
        if (rst_n && o6_valid && out_ready && q6.size() != 0) begin
            m_e6 = q6.pop_front();
            if (m_e6.care) begin
                chk("sat6_dst0", o6_dst0, m_e6.d0);
                chk("sat6_dst1", o6_dst1, m_e6.d1);
                chk("sat6_sat_o", {127'b0, o6_sat}, {127'b0, m_e6.s});
            end
        end
    end

    task automatic send(input logic [127:0] a, input logic [127:0] b,
                        input logic [127:0] c, input logic [2:0] sg,
                        input logic [1:0] o, input logic se,
                        input logic [127:0] x0, input logic [127:0] x1,
                        input logic xs);
        int n;
        q.push_back('{x0, x1, xs});
        q6.push_back('{c6, c6_d0, c6_d1, c6_s});
        src0 = a;
        src1 = b;
        src2 = c;
        sign_s0 = sg[0];
        sign_s1 = sg[1];
        sign_s2 = sg[2];
        op = o;
        sat_en = se;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendu(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [2:0] sg,
                         input logic [1:0] o, input logic se,
                         input logic [3:0] x0, input logic [3:0] x1,
                         input logic xs);
        send(rep(a), rep(b), rep(c), sg, o, se, rep(x0), rep(x1), xs);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q6.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0 || q6.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        src0 = '0;
        src1 = '0;
        src2 = '0;
        sign_s0 = 1'b0;
        sign_s1 = 1'b0;
        sign_s2 = 1'b0;
        op = ADD;
        sat_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst_dst0", dst0, 128'd0);
        chk("rst_dst1", dst1, 128'd0);
        chk("rst_sat_o", {127'b0, sat_o}, 128'd0);
        chk("rst_sat_cnt", {112'b0, sat_cnt}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 0xF x3 unsigned = 45, latency two edges
        sendu(4'hF, 4'hF, 4'hF, 3'b000, ADD, 1'b1, 4'hD, 4'h2, 1'b0);
        @(negedge clk);
        chk("latency_n1", {127'b0, out_valid}, 128'd0);
        @(negedge clk);
        chk("latency_n2", {127'b0, out_valid}, 128'd1);
        drain();

        // signed -8 x3 = -24, mixed signs, mixed lanes
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ADD, 1'b1, 4'h8, 4'hE, 1'b0);
        sendu(4'h8, 4'h8, 4'h8, 3'b010, ADD, 1'b1, 4'h8, 4'h0, 1'b0);
        send({16{8'hF1}}, {16{8'hF2}}, {16{8'hF3}}, 3'b111, ADD, 1'b1,
             {16{8'hD6}}, {16{8'hF0}}, 1'b0);
        drain();

        // ADD and reserved op leave acc alone
        sendu(4'h7, 4'h7, 4'h7, 3'b111, LOAD, 1'b1, 4'h5, 4'h1, 1'b0);
        sendu(4'hF, 4'hF, 4'hF, 3'b000, ADD, 1'b1, 4'hD, 4'h2, 1'b0);
        sendu(4'hF, 4'hF, 4'hF, 3'b000, RSV, 1'b1, 4'hD, 4'h2, 1'b0);
        sendu(4'h0, 4'h0, 4'h0, 3'b000, ACC, 1'b1, 4'h5, 4'h1, 1'b0);
        drain();

        // accumulate to the positive clamp
        sendu(4'h7, 4'h7, 4'h7, 3'b111, LOAD, 1'b1, 4'h5, 4'h1, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b1, 4'hA, 4'h2, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b1, 4'hF, 4'h3, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b1, 4'h4, 4'h5, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b1, 4'h9, 4'h6, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b1, 4'hE, 4'h7, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b1, 4'hF, 4'h7, 1'b1);
        drain();
        chk("sat_cnt_1", {112'b0, sat_cnt}, 128'd1);

        // same chain wrapping: 147 -> 0x93
        sendu(4'h7, 4'h7, 4'h7, 3'b111, LOAD, 1'b0, 4'h5, 4'h1, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b0, 4'hA, 4'h2, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b0, 4'hF, 4'h3, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b0, 4'h4, 4'h5, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b0, 4'h9, 4'h6, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b0, 4'hE, 4'h7, 1'b0);
        sendu(4'h7, 4'h7, 4'h7, 3'b111, ACC, 1'b0, 4'h3, 4'h9, 1'b0);
        drain();
        chk("sat_cnt_wrap", {112'b0, sat_cnt}, 128'd1);

        // accumulate to the negative clamp -128
        sendu(4'h8, 4'h8, 4'h8, 3'b111, LOAD, 1'b1, 4'h8, 4'hE, 1'b0);
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ACC, 1'b1, 4'h0, 4'hD, 1'b0);
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ACC, 1'b1, 4'h8, 4'hB, 1'b0);
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ACC, 1'b1, 4'h0, 4'hA, 1'b0);
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ACC, 1'b1, 4'h8, 4'h8, 1'b0);
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ACC, 1'b1, 4'h0, 4'h8, 1'b1);
        drain();
        chk("sat_cnt_2", {112'b0, sat_cnt}, 128'd2);

        // backpressure: two beats fill the pipe, then release
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                sendu(4'h1, 4'h0, 4'h0, 3'b000, ADD, 1'b1, 4'h1, 4'h0, 1'b0);
                sendu(4'h2, 4'h0, 4'h0, 3'b000, ADD, 1'b1, 4'h2, 4'h0, 1'b0);
                sendu(4'h3, 4'h0, 4'h0, 3'b000, ADD, 1'b1, 4'h3, 4'h0, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_accepts", 128'(n_acc - base), 128'd2);
                @(negedge clk);
                chk("stall_in_ready", {127'b0, in_ready}, 128'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("release_no_gap", {127'b0, out_valid}, 128'd1);
                end
            end
        join
        drain();

        // reset with both stages full and acc near 100
        sendu(4'hF, 4'hF, 4'hF, 3'b000, LOAD, 1'b1, 4'hD, 4'h2, 1'b0);
        sendu(4'hF, 4'hF, 4'hF, 3'b000, ACC, 1'b1, 4'hA, 4'h5, 1'b0);
        sendu(4'h5, 4'h5, 4'h0, 3'b000, ACC, 1'b1, 4'h4, 4'h6, 1'b0);
        drain();
        out_ready = 1'b0;
        sendu(4'h1, 4'h0, 4'h0, 3'b000, ACC, 1'b1, 4'h5, 4'h6, 1'b0);
        sendu(4'h1, 4'h0, 4'h0, 3'b000, ACC, 1'b1, 4'h6, 4'h6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        q6.delete();
        @(negedge clk);
        chk("rst2_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst2_in_ready", {127'b0, in_ready}, 128'd1);
        chk("rst2_sat_cnt", {112'b0, sat_cnt}, 128'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        sendu(4'h1, 4'h0, 4'h0, 3'b000, ACC, 1'b1, 4'h1, 4'h0, 1'b0);
        drain();

        // narrow SAT_W=6 instance: clamp to 31, -24 unclamped
        c6 = 1'b1;
        c6_d0 = rep(4'hF);
        c6_d1 = rep(4'h1);
        c6_s = 1'b1;
        sendu(4'hF, 4'hF, 4'hF, 3'b000, ADD, 1'b1, 4'hD, 4'h2, 1'b0);
        c6_d0 = rep(4'h8);
        c6_d1 = rep(4'hE);
        c6_s = 1'b0;
        sendu(4'h8, 4'h8, 4'h8, 3'b111, ADD, 1'b1, 4'h8, 4'hE, 1'b0);
        c6 = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
